// File: rtl/dm_store_buffer.sv
// Posted-write store buffer between the M-stage store path and the DM write port.
// Optional STBUF_MERGE_EN: full-word stores to the youngest entry's word are merged in place.
module dm_store_buffer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             st_valid,
  output logic             st_ready,
  input  logic [31:0]      st_addr,
  input  logic [3:0]       st_be,
  input  logic [31:0]      st_wd,
  input  logic [31:0]      st_pc8,
  input  logic             ld_valid,
  input  logic [31:0]      ld_addr,
  output logic             ld_stall,
  output logic [31:0]      dm_addr,
  output logic [3:0]       dm_be,
  output logic [31:0]      dm_wd,
  output logic             dm_write,
  output logic [31:0]      dm_pc8,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [31:0]      r_addr [DEPTH];
  logic [3:0]       r_be   [DEPTH];
  logic [31:0]      r_wd   [DEPTH];
  logic [31:0]      r_pc8  [DEPTH];
  logic [DEPTH-1:0] r_valid;
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;

  logic             w_hit;
  logic             w_merge_ok;
  logic             w_merge;
  logic             w_push;
  logic             w_pop;
  logic [PTR_W-1:0] w_wr_idx;

  // Word-granular hazard check against registered entries only
  always_comb begin
    w_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_valid[i] && (r_addr[i][31:2] == ld_addr[31:2])) w_hit = 1'b1;
    end
  end

  assign empty    = (r_count == '0);
  assign full     = (r_count == CNT_W'(DEPTH));
  assign count    = r_count;
  assign ld_stall = ld_valid && w_hit;
  assign dm_write = !empty && (!ld_valid || ld_stall);

`ifdef STBUF_MERGE_EN
  logic [PTR_W-1:0] w_young;
  assign w_young    = r_tail - PTR_W'(1);
  // The head may not be rewritten while it is being handed to DM
  assign w_merge_ok = !empty && (st_be == 4'hF) &&
                      (r_addr[w_young][31:2] == st_addr[31:2]) &&
                      !(dm_write && (w_young == r_head));
  assign w_wr_idx   = w_merge ? w_young : r_tail;
`else
  assign w_merge_ok = 1'b0;
  assign w_wr_idx   = r_tail;
`endif

  assign st_ready = !full || w_merge_ok;
  assign w_merge  = st_valid && w_merge_ok;
  assign w_push   = st_valid && st_ready && !w_merge;
  assign w_pop    = dm_write;

  assign dm_addr = dm_write ? r_addr[r_head] : ld_addr;
  assign dm_be   = dm_write ? r_be[r_head]   : 4'h0;
  assign dm_wd   = dm_write ? r_wd[r_head]   : 32'h0;
  assign dm_pc8  = dm_write ? r_pc8[r_head]  : 32'h0;

  // Payload storage needs no reset; validity is tracked separately
  always_ff @(posedge clk) begin
    if (w_push || w_merge) begin
      r_addr[w_wr_idx] <= st_addr;
      r_be[w_wr_idx]   <= st_be;
      r_wd[w_wr_idx]   <= st_wd;
      r_pc8[w_wr_idx]  <= st_pc8;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_valid <= '0;
    end else begin
      if (w_pop) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + PTR_W'(1);
      end
      if (w_push) begin
        r_valid[r_tail] <= 1'b1;
        r_tail          <= r_tail + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
